hilo_unit: RTL and testbench

- Owns the HI/LO register pair and sequences DIV/DIVU through the 32-iteration unsigned iterative divider.
- Takes multiply/divide/move-to operations from the EX stage and converts signed operands to magnitudes.
- Launches the divider, applies sign correction to its result, and writes HI (remainder) and LO (quotient).
- Generates the pipeline stall for instructions that issue to or read HI/LO while a division is in flight.

---
 rtl/hilo_unit.sv | 138 +++++++++++++
 tb/tb_hilo_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hilo_unit.sv
// HI/LO register pair with DIV/DIVU sequencing around an external unsigned iterative divider.
// Optional single-cycle MULT/MULTU is compiled in when HILO_MULT_EN is defined.
module hilo_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic [2:0]      op_code,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            rd_hilo,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            stall,
  output logic            div_in_valid,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  input  logic [XLEN-1:0] div_remainder,
  input  logic [XLEN-1:0] div_quotient,
  input  logic            div_out_valid
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FIX} state_t;

  localparam logic [2:0] OP_DIV   = 3'd0;
  localparam logic [2:0] OP_DIVU  = 3'd1;
  localparam logic [2:0] OP_MULT  = 3'd2;
  localparam logic [2:0] OP_MULTU = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_t          state, state_next;
  logic [XLEN-1:0] dividend_mag, divisor_mag;
  logic [XLEN-1:0] quo, rem;
  logic            neg_q, neg_r;
  logic            signed_div;

  // |0x8000_0000| wraps back to 0x8000_0000, which is the correct unsigned magnitude.
  function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] v);
    return v[XLEN-1] ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] cond_negate(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

`ifdef HILO_MULT_EN
  logic signed [2*XLEN-1:0] mul_a, mul_b, product;

  // Sign- or zero-extend to full product width; the low 2*XLEN bits are then exact.
  always_comb begin
    mul_a   = {{XLEN{(op_code == OP_MULT) & rs_data[XLEN-1]}}, rs_data};
    mul_b   = {{XLEN{(op_code == OP_MULT) & rt_data[XLEN-1]}}, rt_data};
    product = mul_a * mul_b;
  end
`endif

  assign signed_div   = (op_code == OP_DIV);
  assign stall        = busy & (op_valid | rd_hilo);
  assign div_dividend = dividend_mag;
  assign div_divisor  = divisor_mag;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (op_valid && (op_code == OP_DIV || op_code == OP_DIVU) && rt_data != '0)
          state_next = LAUNCH;
      end
      LAUNCH:  state_next = WAIT;
      WAIT:    if (div_out_valid) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi           <= '0;
      lo           <= '0;
      busy         <= 1'b0;
      div_in_valid <= 1'b0;
      dividend_mag <= '0;
      divisor_mag  <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      quo          <= '0;
      rem          <= '0;
    end else begin
      div_in_valid <= (state_next == LAUNCH);
      busy         <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (op_valid) begin
            case (op_code)
              OP_DIV, OP_DIVU: begin
                if (rt_data == '0) begin
                  hi <= rs_data;
                  lo <= '1;
                end else begin
                  dividend_mag <= signed_div ? magnitude(rs_data) : rs_data;
                  divisor_mag  <= signed_div ? magnitude(rt_data) : rt_data;
                  neg_q        <= signed_div & (rs_data[XLEN-1] ^ rt_data[XLEN-1]);
                  neg_r        <= signed_div & rs_data[XLEN-1];
                end
              end
              OP_MTHI: hi <= rs_data;
              OP_MTLO: lo <= rs_data;
`ifdef HILO_MULT_EN
              OP_MULT, OP_MULTU: {hi, lo} <= product;
`endif
              default: ;
            endcase
          end
        end
        WAIT: begin
          if (div_out_valid) begin
            quo <= div_quotient;
            rem <= div_remainder;
          end
        end
        FIX: begin
          lo <= cond_negate(quo, neg_q);
          hi <= cond_negate(rem, neg_r);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: the divider is emulated by driving hand-computed
// unsigned quotient/remainder after a chosen latency.
module tb_hilo_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op_code = 3'd0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        rd_hilo = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, stall, div_in_valid;
  logic [31:0] div_dividend, div_divisor;
  logic [31:0] div_remainder = '0;
  logic [31:0] div_quotient = '0;
  logic        div_out_valid = 1'b0;

  int checks = 0;
  int errors = 0;

  hilo_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .rs_data(rs_data), .rt_data(rt_data), .rd_hilo(rd_hilo),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall),
    .div_in_valid(div_in_valid), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_remainder(div_remainder), .div_quotient(div_quotient), .div_out_valid(div_out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue in IDLE; the issuing op must never see stall. Returns one cycle later.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op_code  = op;
    rs_data  = a;
    rt_data  = b;
    #1;
    check("issue_no_stall", 32'(stall), 32'd0);
    step();
    op_valid = 1'b0;
  endtask

  task automatic run_div(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_dd,
                         input logic [31:0] exp_dv, input logic [31:0] q,
                         input logic [31:0] r, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int lat);
    issue(op, a, b);
    check({tag, "_launch"}, 32'(div_in_valid), 32'd1);
    check({tag, "_dividend"}, div_dividend, exp_dd);
    check({tag, "_divisor"}, div_divisor, exp_dv);
    check({tag, "_busy_launch"}, 32'(busy), 32'd1);
    step();
    check({tag, "_pulse_once"}, 32'(div_in_valid), 32'd0);
    for (int i = 1; i < lat; i++) step();
    check({tag, "_busy_wait"}, 32'(busy), 32'd1);
    div_quotient  = q;
    div_remainder = r;
    div_out_valid = 1'b1;
    step();
    div_out_valid = 1'b0;
    check({tag, "_busy_fix"}, 32'(busy), 32'd1);
    step();
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_div_in_valid", 32'(div_in_valid), 32'd0);
    rst = 1'b0;
    step();

    // Divides: companion latency first, then a short emulated latency
    run_div("divu_100_7", 3'd1, 32'd100, 32'd7, 32'd100, 32'd7,
            32'd14, 32'd2, 32'd2, 32'd14, 33);
    run_div("div_m7_2", 3'd0, 32'hFFFF_FFF9, 32'd2, 32'd7, 32'd2,
            32'd3, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 3);
    run_div("div_min_m1", 3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1,
            32'h8000_0000, 32'd0, 32'd0, 32'h8000_0000, 2);

    // Divide by zero
    issue(3'd0, 32'h0000_1234, 32'd0);
    check("dz_no_launch", 32'(div_in_valid), 32'd0);
    check("dz_busy", 32'(busy), 32'd0);
    check("dz_hi", hi, 32'h0000_1234);
    check("dz_lo", lo, 32'hFFFF_FFFF);

    // Move-to
    issue(3'd4, 32'hAAAA_5555, 32'd0);
    check("mthi_hi", hi, 32'hAAAA_5555);
    check("mthi_lo", lo, 32'hFFFF_FFFF);
    issue(3'd5, 32'h0F0F_0F0F, 32'd0);
    check("mtlo_lo", lo, 32'h0F0F_0F0F);
    check("mtlo_hi", hi, 32'hAAAA_5555);

    // Multiply
    issue(3'd2, 32'hFFFF_FFFF, 32'd3);
`ifdef HILO_MULT_EN
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFD);
    check("mult_busy", 32'(busy), 32'd0);
    issue(3'd3, 32'hFFFF_FFFF, 32'd3);
    check("multu_hi", hi, 32'd2);
    check("multu_lo", lo, 32'hFFFF_FFFD);
    issue(3'd4, 32'hAAAA_5555, 32'd0);
    issue(3'd5, 32'h0F0F_0F0F, 32'd0);
`else
    check("mult_off_hi", hi, 32'hAAAA_5555);
    check("mult_off_lo", lo, 32'h0F0F_0F0F);
    issue(3'd3, 32'hFFFF_FFFF, 32'd3);
    check("multu_off_hi", hi, 32'hAAAA_5555);
    check("multu_off_lo", lo, 32'h0F0F_0F0F);
`endif

    // Unrecognised op and stray divider result in IDLE
    issue(3'd7, 32'h1111_1111, 32'd5);
    check("nop_hi", hi, 32'hAAAA_5555);
    check("nop_lo", lo, 32'h0F0F_0F0F);
    div_quotient  = 32'h5A5A_5A5A;
    div_remainder = 32'hA5A5_A5A5;
    div_out_valid = 1'b1;
    step();
    div_out_valid = 1'b0;
    step();
    step();
    check("stray_hi", hi, 32'hAAAA_5555);
    check("stray_lo", lo, 32'h0F0F_0F0F);
    check("stray_busy", 32'(busy), 32'd0);

    // Stall from reader and from an op issued while busy
    issue(3'd1, 32'd50, 32'd5);
    rd_hilo = 1'b1;
    #1;
    check("stall_launch", 32'(stall), 32'd1);
    step();
    op_valid = 1'b1;
    op_code  = 3'd4;
    rs_data  = 32'hDEAD_BEEF;
    #1;
    check("stall_wait", 32'(stall), 32'd1);
    step();
    check("stall_wait2", 32'(stall), 32'd1);
    div_quotient  = 32'd10;
    div_remainder = 32'd0;
    div_out_valid = 1'b1;
    step();
    div_out_valid = 1'b0;
    check("stall_fix", 32'(stall), 32'd1);
    step();
    check("stall_idle", 32'(stall), 32'd0);
    check("stall_hi", hi, 32'd0);
    check("stall_lo", lo, 32'd10);
    op_valid = 1'b0;
    rd_hilo  = 1'b0;
    step();
    check("mthi_busy_ignored", hi, 32'd0);

    // Reset during WAIT, then a late divider result
    issue(3'd1, 32'd9, 32'd3);
    step();
    step();
    rst = 1'b1;
    #1;
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_dd", div_dividend, 32'd0);
    step();
    rst = 1'b0;
    div_quotient  = 32'd3;
    div_remainder = 32'd0;
    div_out_valid = 1'b1;
    step();
    div_out_valid = 1'b0;
    step();
    step();
    check("late_hi", hi, 32'd0);
    check("late_lo", lo, 32'd0);
    check("late_busy", 32'(busy), 32'd0);
    check("late_launch", 32'(div_in_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
